// File: rtl/mod_n_counter.sv
// Synchronous modulo-N counter with enable, direction, parallel load and
// terminal-count indication. The count register is the only state.
module mod_n_counter #(
    parameter int N     = 10,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] cout,
    output logic             tc
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(N - 1);

    generate
        if (N < 2 || longint'(N) > (longint'(1) << WIDTH)) begin : g_bad_modulus
            $error("mod_n_counter: N must satisfy 2 <= N <= 2**WIDTH");
        end
    endgenerate

    logic at_max;
    logic at_zero;

    assign at_max  = (cout == MAX_VAL);
    assign at_zero = (cout == '0);

    // Range checks compare against N-1 so they still fit in WIDTH bits when
    // N == 2**WIDTH; the explicit wrap then coincides with natural overflow.
    // NOTE: state is updated with non-blocking assignments so every reader in
    // the same edge sees the pre-edge count.
    always_ff @(posedge clk) begin
        if (rst) begin
            cout <= '0;
        end else if (load) begin
            cout <= (load_val <= MAX_VAL) ? load_val : '0;
        end else if (en) begin
            if (up_dn) begin
                cout <= at_max ? '0 : cout + WIDTH'(1);
            end else begin
                cout <= at_zero ? MAX_VAL : cout - WIDTH'(1);
            end
        end
    end

    assign tc = en & ~load & ~rst & ((up_dn & at_max) | (~up_dn & at_zero));

endmodule

// File: tb/tb_mod_n_counter.sv
// Directed self-checking bench for mod_n_counter, covering N = 10 and the
// power-of-two case N = 16 with WIDTH = 4.
module tb_mod_n_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       up_dn;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] d10_cout;
    logic       d10_tc;
    logic [3:0] d16_cout;
    logic       d16_tc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mod_n_counter #(.N(10), .WIDTH(4)) dut10 (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up_dn    (up_dn),
        .load     (load),
        .load_val (load_val),
        .cout     (d10_cout),
        .tc       (d10_tc)
    );

    mod_n_counter #(.N(16), .WIDTH(4)) dut16 (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up_dn    (up_dn),
        .load     (load),
        .load_val (load_val),
        .cout     (d16_cout),
        .tc       (d16_tc)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_cnt;

        rst      = 1'b1;
        en       = 1'b1;
        up_dn    = 1'b1;
        load     = 1'b0;
        load_val = 4'd0;

        // Reset held for two edges
        tick();
        tick();
        check("reset_cout10", d10_cout, 0);
        check("reset_cout16", d16_cout, 0);
        check("reset_tc10", d10_tc, 0);
        check("reset_tc16", d16_tc, 0);

        // Free-run up: three full periods
        rst     = 1'b0;
        exp_cnt = 0;
        #1;
        for (int i = 0; i < 30; i++) begin
            check($sformatf("run_tc_%0d", i), d10_tc, (exp_cnt == 9) ? 1 : 0);
            tick();
            exp_cnt = (exp_cnt == 9) ? 0 : exp_cnt + 1;
            check($sformatf("run_cout_%0d", i), d10_cout, exp_cnt);
        end
        check("run_end_zero", d10_cout, 0);

        // Mid-run reset at count 6
        repeat (6) tick();
        check("pre_reset6", d10_cout, 6);
        rst = 1'b1;
        #1;
        check("tc_in_reset", d10_tc, 0);
        tick();
        check("midreset_cout", d10_cout, 0);
        rst = 1'b0;
        tick();
        check("resume_1", d10_cout, 1);
        tick();
        check("resume_2", d10_cout, 2);

        // Down count across the wrap
        up_dn = 1'b0;
        tick();
        check("down_1", d10_cout, 1);
        check("down_tc_at1", d10_tc, 0);
        tick();
        check("down_0", d10_cout, 0);
        check("down_tc_at0", d10_tc, 1);
        tick();
        check("down_9", d10_cout, 9);
        tick();
        check("down_8", d10_cout, 8);

        // Parallel load, including out-of-range and boundary values
        load     = 1'b1;
        load_val = 4'd7;
        #1;
        check("load_tc", d10_tc, 0);
        tick();
        check("load_7", d10_cout, 7);
        load_val = 4'd12;
        tick();
        check("load_12", d10_cout, 0);
        load_val = 4'd10;
        tick();
        check("load_10", d10_cout, 0);
        load_val = 4'd9;
        tick();
        check("load_9", d10_cout, 9);
        load  = 1'b0;
        up_dn = 1'b1;
        #1;
        check("tc_at9_up", d10_tc, 1);
        load     = 1'b1;
        load_val = 4'd3;
        #1;
        check("load_en_tc", d10_tc, 0);
        tick();
        check("load_en_3", d10_cout, 3);

        // Enable gating at count 4
        load_val = 4'd4;
        tick();
        check("load_4", d10_cout, 4);
        load = 1'b0;
        en   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("hold_tc_%0d", i), d10_tc, 0);
            tick();
            check($sformatf("hold_cout_%0d", i), d10_cout, 4);
        end
        en = 1'b1;
        tick();
        check("reenable_5", d10_cout, 5);

        // Power-of-two modulus
        rst = 1'b1;
        tick();
        check("p2_reset", d16_cout, 0);
        rst = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            tick();
            check($sformatf("p2_up_%0d", i), d16_cout, i);
        end
        check("p2_tc_at15", d16_tc, 1);
        tick();
        check("p2_wrap_0", d16_cout, 0);
        check("p2_tc_at0_up", d16_tc, 0);
        up_dn = 1'b0;
        #1;
        check("p2_tc_at0_down", d16_tc, 1);
        tick();
        check("p2_down_15", d16_cout, 15);
        tick();
        check("p2_down_14", d16_cout, 14);
        load     = 1'b1;
        load_val = 4'd15;
        tick();
        check("p2_load_15", d16_cout, 15);
        check("n10_load_15", d10_cout, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mod_n_counter.md
# mod_n_counter

Parameterised synchronous modulo-N counter. It cycles through 0..N-1 and wraps, with count enable, direction control, parallel load and a terminal-count indication. It is a general-purpose sequencing and timebase primitive: it drives divided enables, slot indices and tick generation for other datapath blocks.

## Interface

Parameters:
- N, default 10: modulus. Legal range 2 ≤ N ≤ 2^WIDTH; any other value is an elaboration-time error.
- WIDTH, default 4: counter width in bits.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  count enable; tie high for free-running operation.
- up_dn  input  1  direction; 1 = count up, 0 = count down.
- load  input  1  synchronous parallel-load strobe.
- load_val  input  WIDTH  value to load.
- cout  output  WIDTH  current count, registered.
- tc  output  1  terminal count, combinational: the next enabled edge wraps.

One clock; reset is synchronous and active-high.

## Operation

Each rising edge of clk applies the first matching row, in this priority:
1. rst = 1: cout ← 0.
2. load = 1:
   - If load_val < N, cout ← load_val.
   - If load_val ≥ N, cout ← 0.
   - load overrides en and up_dn.
3. en = 1, up_dn = 1:
   - If cout == N-1, cout ← 0.
   - Otherwise cout ← cout+1.
4. en = 1, up_dn = 0:
   - If cout == 0, cout ← N-1.
   - Otherwise cout ← cout-1.
5. Otherwise cout holds.

Terminal count:
- tc = en & ~load & ~rst & ((up_dn & cout==N-1) | (~up_dn & cout==0)).
- tc is 1 exactly during the cycle before a wrap edge.

Arithmetic and range:
- Comparisons and increments are done at WIDTH bits.
- No intermediate value may exceed N-1, including when N = 2^WIDTH (natural overflow must agree with the explicit wrap).
- cout is always in 0..N-1 after the first reset edge.

Other rules:
- Direction may change on any cycle. The new direction takes effect on the same edge with no extra latency.
- There is no internal state besides the count register.

## Timing

- Output latency: cout changes one clk edge after the controlling input is sampled high.
- Reset:
  - rst sampled high at an edge → cout = 0 after that edge.
  - During reset, tc = 0.
  - There is no asynchronous path; before the first reset edge, cout is undefined (X in simulation).
- Mid-run reset: asserting rst at any count forces cout = 0 on the next edge. Counting resumes on the first edge with rst low and en high: 0 → 1 (up).
- Full period: free-running up count (en = 1, up_dn = 1) returns to the same value every N cycles. The sequence is 0, 1, …, N-1, 0.
- Simultaneous events:
  - rst + load → reset wins.
  - load + en → load wins, and tc = 0 that cycle.
- tc is glitch-free with respect to cout: it is derived only from registered cout and the inputs sampled that cycle.

## Test plan

- Reset then free-run (N = 10, WIDTH = 4, en = 1, up_dn = 1):
  - Hold rst for 2 edges, release, run 30 cycles.
  - Required: cout = 0,1,…,9,0,… exactly three full periods.
  - tc high only when cout = 9.
- Mid-run reset:
  - Free-run to cout = 6, assert rst for one edge.
  - Required: cout = 0 after that edge, then 1, 2 after release.
- Down count and wrap:
  - From cout = 1 with up_dn = 0, en = 1.
  - Required: cout = 0, 9, 8.
  - tc high when cout = 0.
- Load:
  - load_val = 7 → cout = 7 on the next edge.
  - load_val = 12 (≥ N) → cout = 0.
  - Assert load and en together at cout = 9 with load_val = 3 → cout = 3, and tc = 0 that cycle.
- Enable gating:
  - en = 0 for 5 cycles at cout = 4.
  - Required: cout stays 4 and tc = 0.
  - Re-enable → 5.
- Power-of-two modulus (N = 16, WIDTH = 4):
  - Free-run up.
  - Required: cout goes 15 → 0 with tc = 1 at 15.
  - Down from 0 → 15.
